load_store_unit: RTL

- Sits between the MIPS datapath (ALU result / rt operand) and the word-addressed data memory.
- Handles lb/lbu/lh/lhu/lw/sb/sh/sw and their alignment checks.
- The memory has one synchronous-read cycle of latency and no byte enables. Loads therefore take a wait cycle, and sub-word stores use a read-modify-write sequence.
- Stalls the core through `busy` until the access finishes.

---
 rtl/load_store_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Byte/half/word load-store adapter between the MIPS datapath and a word-wide synchronous RAM.
// Latency: load 3, sub-word store 3 (read-modify-write), word store 2, misaligned 1 cycle to done.
// No queueing: req is sampled only while idle; busy stalls the core until the done cycle.
module load_store_unit #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [1:0]            size,
    input  logic                  unsigned_ld,
    input  logic [ADDR_WIDTH+1:0] byte_addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  done,
    output logic                  misaligned,
    output logic                  busy,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_READ    = 3'd1;
    localparam logic [2:0] S_EXTRACT = 3'd2;
    localparam logic [2:0] S_MERGE   = 3'd3;
    localparam logic [2:0] S_WRITE   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]            state;
    logic                  lat_we;
    logic [1:0]            lat_size;
    logic                  lat_uns;
    logic [ADDR_WIDTH+1:0] lat_addr;
    logic [31:0]           lat_wdata;
    logic                  err;

    logic                  req_mis;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [31:0]           ld_val;
    logic [31:0]           merged;

    assign req_mis = (size == 2'b11)
                   | ((size == 2'b01) & byte_addr[0])
                   | ((size == 2'b10) & (byte_addr[1:0] != 2'b00));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            lat_we    <= 1'b0;
            lat_size  <= 2'b00;
            lat_uns   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= 32'h0;
            err       <= 1'b0;
            rdata     <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        lat_we    <= we;
                        lat_size  <= size;
                        lat_uns   <= unsigned_ld;
                        lat_addr  <= byte_addr;
                        lat_wdata <= wdata;
                        err       <= req_mis;
                        // Only a full-word store can skip the read; everything else needs the old word.
                        if (req_mis)
                            state <= S_DONE;
                        else if (we && size == 2'b10)
                            state <= S_WRITE;
                        else
                            state <= S_READ;
                    end
                end
                S_READ:    state <= lat_we ? S_MERGE : S_EXTRACT;
                S_EXTRACT: begin
                    rdata <= ld_val;
                    state <= S_DONE;
                end
                S_MERGE:   state <= S_DONE;
                S_WRITE:   state <= S_DONE;
                S_DONE:    state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        ld_byte = 8'h00;
        case (lat_addr[1:0])
            2'b00: ld_byte = mem_rdata[7:0];
            2'b01: ld_byte = mem_rdata[15:8];
            2'b10: ld_byte = mem_rdata[23:16];
            2'b11: ld_byte = mem_rdata[31:24];
            default: ld_byte = 8'h00;
        endcase
        ld_half = lat_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (lat_size)
            2'b00:   ld_val = lat_uns ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_val = lat_uns ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_val = mem_rdata;
        endcase
    end

    // Replace only the addressed lane of the word fetched in READ; the RAM holds it on mem_rdata.
    always_comb begin
        merged = mem_rdata;
        if (lat_size == 2'b00) begin
            case (lat_addr[1:0])
                2'b00: merged[7:0]   = lat_wdata[7:0];
                2'b01: merged[15:8]  = lat_wdata[7:0];
                2'b10: merged[23:16] = lat_wdata[7:0];
                2'b11: merged[31:24] = lat_wdata[7:0];
                default: merged = mem_rdata;
            endcase
        end else if (lat_addr[1]) begin
            merged[31:16] = lat_wdata[15:0];
        end else begin
            merged[15:0] = lat_wdata[15:0];
        end
    end

    always_comb begin
        case (state)
            S_MERGE: mem_wdata = merged;
            S_WRITE: mem_wdata = lat_wdata;
            default: mem_wdata = 32'h0;
        endcase
    end

    assign mem_read   = (state == S_READ);
    assign mem_write  = (state == S_MERGE) | (state == S_WRITE);
    assign done       = (state == S_DONE);
    assign misaligned = (state == S_DONE) & err;
    assign busy       = (state != S_IDLE);
    assign mem_addr   = lat_addr[ADDR_WIDTH+1:2];

endmodule
